mem_sys_ctrl: RTL
=================

// Module: mem_sys_ctrl
// PURPOSE
//  Request-side controller for the memory system; sits directly upstream of the ROM/RAM pair and their output mux.
//  - Accepts one word request at a time on a valid/ready handshake.
//  - Decodes the address into the ROM or RAM region and drives that memory's address, write-enable and write data.
//  - Captures the selected read word into a held response register, replacing the bare ROM/RAM output mux.
//  - Flags illegal accesses (writes to ROM) and counts them.
// PARAMETERS
//  DATA_WIDTH  32  word width; taken from my_pkg, not overridden locally
//  ADDR_WIDTH  64  words per memory; taken from my_pkg; index width IDX_W = $clog2(ADDR_WIDTH) = 6
//  ERR_CNT_W   8   width of the saturating illegal-access counter
// PORTS
//  clk        in   1        single clock; all state updates on posedge
//  rst        in   1        synchronous, active-high reset
//  req_valid  in   1        request present
//  req_ready  out  1        controller can accept; high only in IDLE
//  req_we     in   1        1 = write, 0 = read
//  req_addr   in   IDX_W+1  [IDX_W] region select: 0 = ROM, 1 = RAM; [IDX_W-1:0] word index
//  req_wdata  in   DATA_W   write word
//  rom_addr   out  IDX_W    ROM word index
//  rom_rdata  in   DATA_W   ROM read word; synchronous, 1-cycle read latency
//  ram_addr   out  IDX_W    RAM word index
//  ram_we     out  1        RAM write strobe
//  ram_wdata  out  DATA_W   RAM write word
//  ram_rdata  in   DATA_W   RAM read word; synchronous, 1-cycle read latency
//  rsp_valid  out  1        response held
//  rsp_ready  in   1        consumer takes response
//  rsp_rdata  out  DATA_W   read word; 0 for writes and errors
//  rsp_err    out  1        1 = illegal access (write to ROM)
//  err_cnt    out  ERR_CNT_W  count of illegal accesses; saturates at all-ones
// BEHAVIOUR
//  - Reset values: state = IDLE, req_ready = 1 on the first cycle after reset. All of the following are 0:
//    rsp_valid, rsp_err, rsp_rdata, ram_we, ram_wdata, rom_addr, ram_addr, err_cnt.
//  - FSM states are IDLE, ACCESS, WAIT and RESP.
//  - Request latch: a handshake (req_valid & req_ready) in IDLE latches we, addr and wdata.
//  - Transitions out of IDLE:
//    - RAM read or RAM write -> ACCESS.
//    - ROM read -> ACCESS.
//    - ROM write -> RESP with rsp_err = 1 and rsp_rdata = 0; err_cnt increments, saturating.
//  - ACCESS (one cycle): drive the latched index on the selected rom_addr/ram_addr.
//    - RAM write: ram_we = 1 for exactly this cycle, ram_wdata = latched word; next state is RESP.
//    - Read: next state is WAIT.
//  - WAIT (one cycle): rsp_rdata <= (region ? ram_rdata : rom_rdata); next state is RESP.
//  - RESP: rsp_valid = 1; rsp_rdata and rsp_err are held stable until rsp_ready.
//    - On rsp_ready: rsp_valid -> 0, rsp_err -> 0, next state is IDLE.
//    - req_ready is not asserted in the same cycle; there is no response/request overlap.
//  - Latency from the accept edge N (all with rsp_ready held high):
//    - Read: rsp_valid at N+3.
//    - RAM write: rsp_valid at N+2.
//    - ROM write: rsp_valid at N+1.
//    - Back-to-back throughput: read = 1 per 4 cycles.
//  - Address outputs hold their last value outside ACCESS/WAIT. ram_we is 0 in every state except ACCESS-write.
//  - req_* inputs are ignored outside IDLE; a request held across RESP is accepted on return to IDLE.
//  - rsp_ready low in RESP: stall indefinitely; no output changes.
//  - Index wrap: the index is used as-is. Index 63 is legal and there is no carry into the region bit.
//  - err_cnt saturation: at 2^ERR_CNT_W-1 it stays there; rsp_err still asserts.
//  - Reset mid-operation: next edge forces IDLE.
//    - Any pending response is discarded (rsp_valid = 0).
//    - ram_we = 0 on that edge; an in-flight write that has not reached ACCESS is never performed.
//    - err_cnt clears.
// STRUCTURE
//  - Add to my_pkg:
//    - localparam IDX_W = $clog2(ADDR_WIDTH).
//    - typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} ctrl_state_e.
//    - typedef enum logic {SEL_ROM, SEL_RAM} mem_sel_e.
//    - typedef struct packed {logic we; mem_sel_e sel; logic [IDX_W-1:0] idx; logic [DATA_WIDTH-1:0] wdata;} mem_req_t.
//  - Existing inter_rom/inter_ram typedefs type rom_rdata/ram_rdata.
//  - One sub-module, mem_addr_decode: combinational split of req_addr into mem_sel_e plus index, and the ROM-write illegal flag.
//  - The FSM, request register and response register stay in this module.
// TESTING
//  - RAM write then read:
//    - Write 0xDEADBEEF at addr 0x45 -> ram_we = 1 exactly one cycle with ram_addr = 5; rsp_valid at N+2, rsp_err = 0.
//    - Read 0x45 -> rsp_rdata = 0xDEADBEEF at N+3.
//  - ROM read: preload ROM[0x3F] = 0x12345678; read addr 0x3F -> rom_addr = 63, rsp_rdata = 0x12345678.
//    Also checks that index 63 does not spill into RAM.
//  - ROM write: addr 0x02, data 0xFFFFFFFF -> ram_we never asserts; rsp_err = 1 and rsp_rdata = 0 at N+1; err_cnt = 1.
//    Repeat 300 times -> err_cnt saturates at 255.
//  - Backpressure: hold rsp_ready = 0 for 10 cycles in RESP with req_valid high.
//    -> rsp_* stable, req_ready = 0, no second accept.
//    -> Release: exactly one response; next request is accepted the cycle after.
//  - Reset mid-op: assert rst in WAIT of a read.
//    -> Next cycle rsp_valid = 0, req_ready = 1, err_cnt = 0, no response ever appears.
//    -> Assert rst in the accept cycle of a RAM write -> RAM contents unchanged.
//  - Random mix: 1000 random reads/writes vs a scoreboard model with random rsp_ready.
//    -> All data and err values match; ram_we count equals the number of accepted RAM writes.

Source files
------------

// File: rtl/my_pkg.sv
// Shared memory-system types: word/array sizing, ROM/RAM read-word types and
// the request-controller FSM, region-select and request-record types.
package my_pkg;

   localparam int DATA_WIDTH = 32;
   localparam int ADDR_WIDTH = 64;
   localparam int IDX_W      = $clog2(ADDR_WIDTH);

   typedef logic [DATA_WIDTH-1:0] inter_rom;
   typedef logic [DATA_WIDTH-1:0] inter_ram;

   typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} ctrl_state_e;

   typedef enum logic {SEL_ROM, SEL_RAM} mem_sel_e;

   typedef struct packed {
      logic                  we;
      mem_sel_e              sel;
      logic [IDX_W-1:0]      idx;
      logic [DATA_WIDTH-1:0] wdata;
   } mem_req_t;

endpackage

// File: rtl/mem_addr_decode.sv
// Splits a request address into region select and word index, and flags
// writes aimed at the read-only region.
module mem_addr_decode
   import my_pkg::*;
(
   input  logic [IDX_W:0]   req_addr,
   input  logic             req_we,
   output mem_sel_e         sel,
   output logic [IDX_W-1:0] idx,
   output logic             illegal
);

   // The index is taken as-is; it never carries into the region bit.
   assign sel     = mem_sel_e'(req_addr[IDX_W]);
   assign idx     = req_addr[IDX_W-1:0];
   assign illegal = req_we && (sel == SEL_ROM);

endmodule

// File: rtl/mem_sys_ctrl.sv
// Request-side controller for the ROM/RAM pair: single outstanding request,
// region decode, held read response and a saturating illegal-write counter.
module mem_sys_ctrl
   import my_pkg::*;
#(
   parameter int ERR_CNT_W = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [IDX_W:0]        req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic [IDX_W-1:0]      rom_addr,
   input  inter_rom              rom_rdata,
   output logic [IDX_W-1:0]      ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  inter_ram              ram_rdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  rsp_err,
   output logic [ERR_CNT_W-1:0]  err_cnt
);

   ctrl_state_e      state;
   mem_req_t         req_q;
   logic [IDX_W-1:0] rom_addr_q;
   logic [IDX_W-1:0] ram_addr_q;

   mem_sel_e         dec_sel;
   logic [IDX_W-1:0] dec_idx;
   logic             dec_illegal;

   function automatic logic [ERR_CNT_W-1:0] sat_inc(input logic [ERR_CNT_W-1:0] v);
      return (&v) ? v : v + ERR_CNT_W'(1);
   endfunction

   mem_addr_decode u_decode (
      .req_addr (req_addr),
      .req_we   (req_we),
      .sel      (dec_sel),
      .idx      (dec_idx),
      .illegal  (dec_illegal)
   );

   // Memory ports present the latched request during ACCESS and otherwise hold
   // the last index each memory saw.
   assign rom_addr  = (state == ACCESS && req_q.sel == SEL_ROM) ? req_q.idx : rom_addr_q;
   assign ram_addr  = (state == ACCESS && req_q.sel == SEL_RAM) ? req_q.idx : ram_addr_q;
   assign ram_we    = (state == ACCESS) && req_q.we && (req_q.sel == SEL_RAM);
   assign ram_wdata = req_q.wdata;

   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         req_ready  <= 1'b1;
         req_q      <= '0;
         rom_addr_q <= '0;
         ram_addr_q <= '0;
         rsp_valid  <= 1'b0;
         rsp_err    <= 1'b0;
         rsp_rdata  <= '0;
         err_cnt    <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid && req_ready) begin
                  req_q     <= '{we: req_we, sel: dec_sel, idx: dec_idx, wdata: req_wdata};
                  req_ready <= 1'b0;
                  if (dec_illegal) begin
                     state     <= RESP;
                     rsp_valid <= 1'b1;
                     rsp_err   <= 1'b1;
                     rsp_rdata <= '0;
                     err_cnt   <= sat_inc(err_cnt);
                  end else begin
                     state <= ACCESS;
                  end
               end
            end
            ACCESS: begin
               if (req_q.sel == SEL_RAM) ram_addr_q <= req_q.idx;
               else                      rom_addr_q <= req_q.idx;
               if (req_q.we) begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
               end else begin
                  state <= WAIT;
               end
            end
            // Read data arrives one cycle after ACCESS presented the address.
            WAIT: begin
               rsp_rdata <= (req_q.sel == SEL_RAM) ? ram_rdata : rom_rdata;
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid <= 1'b0;
                  rsp_err   <= 1'b0;
                  req_ready <= 1'b1;
                  state     <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
